// File: rtl/pixel_write_arbiter.sv
// ---------------------------------------------------------------------------
// pixel_write_arbiter
//
// Shares the single framebuffer pixel-write port between three pixel-drawing
// requesters (line generator, trace plotter, text overlay, ...). Each
// requester holds a pixel (X, Y, RGB) with a level request. One requester is
// granted per cycle in round-robin order, and the granted pixel is issued to
// the framebuffer as a registered one-cycle write.
//
// Optional feature (compile-time macro PIXEL_CLIP_EN):
//   defined   - granted pixels with X > MAX_X or Y > MAX_Y are consumed
//               (the requester advances) but not written; drop_cnt counts
//               them and saturates at 16'hFFFF.
//   undefined - no coordinate check; every grant writes; drop_cnt is 0.
//
// Parameters:
//   MAX_X, MAX_Y  largest valid coordinate (inclusive), clipping only
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req[2:0]   per-requester level request
//   x_in[23:0] requester X, 8 bits each, requester i at [8i+7:8i]
//   y_in[23:0] requester Y, same packing as x_in
//   rgb_in     requester colour, 12 bits each, requester i at [12i+11:12i]
//   fb_ready   framebuffer can accept a write; gates new grants only
//   gnt[2:0]   one-hot combinational grant
//   X_loc      registered pixel X to the framebuffer
//   Y_loc      registered pixel Y to the framebuffer
//   RGB        registered pixel colour to the framebuffer
//   WR_en      registered single-cycle write strobe
//   drop_cnt   saturating count of clipped pixels
// ---------------------------------------------------------------------------
module pixel_write_arbiter #(
    parameter int MAX_X = 120,
    parameter int MAX_Y = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [23:0] x_in,
    input  logic [23:0] y_in,
    input  logic [35:0] rgb_in,
    input  logic        fb_ready,
    output logic [2:0]  gnt,
    output logic [7:0]  X_loc,
    output logic [7:0]  Y_loc,
    output logic [11:0] RGB,
    output logic        WR_en,
    output logic [15:0] drop_cnt
);

    localparam int N_REQ = 3;

    // -----------------------------------------------------------------------
    // Unpack the flat requester buses into per-requester arrays
    // -----------------------------------------------------------------------
    logic [7:0]  x_arr   [N_REQ];
    logic [7:0]  y_arr   [N_REQ];
    logic [11:0] rgb_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign x_arr[gi]   = x_in[8*gi +: 8];
            assign y_arr[gi]   = y_in[8*gi +: 8];
            assign rgb_arr[gi] = rgb_in[12*gi +: 12];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]  last_reg,  last_next;
    logic [7:0]  x_loc_reg, x_loc_next;
    logic [7:0]  y_loc_reg, y_loc_next;
    logic [11:0] rgb_reg,   rgb_next;
    logic        wr_en_reg, wr_en_next;

    // Combinational grant results
    logic        gnt_any;
    logic [1:0]  gnt_idx;
    logic [1:0]  cand_idx;
    logic [2:0]  gnt_onehot;

    // Data of the granted requester
    logic [7:0]  sel_x;
    logic [7:0]  sel_y;
    logic [11:0] sel_rgb;
    logic        clip_hit;
    logic        write_fire;

    // (base + offset) mod 3 for base in 0..2 and offset in 1..3; the sum never
    // exceeds 5 so a single conditional subtract is enough.
    function automatic logic [1:0] rr_index(input logic [1:0] base,
                                            input logic [1:0] offset);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, offset};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    // -----------------------------------------------------------------------
    // Round-robin grant: search last+1, last+2, last. Reset is included so
    // that gnt drops immediately when rst rises, not at the next edge.
    // -----------------------------------------------------------------------
    always_comb begin
        gnt_any    = 1'b0;
        gnt_idx    = last_reg;
        cand_idx   = last_reg;
        gnt_onehot = 3'b000;
        if (!rst && fb_ready) begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand_idx = rr_index(last_reg, 2'(k));
                if (!gnt_any && req[cand_idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand_idx;
                end
            end
        end
        if (gnt_any) begin
            gnt_onehot = 3'b001 << gnt_idx;
        end
    end

    assign gnt = gnt_onehot;

    assign sel_x   = x_arr[gnt_idx];
    assign sel_y   = y_arr[gnt_idx];
    assign sel_rgb = rgb_arr[gnt_idx];

`ifdef PIXEL_CLIP_EN
    // Out-of-range pixels are still granted so the requester moves on.
    assign clip_hit = (int'(sel_x) > MAX_X) || (int'(sel_y) > MAX_Y);
`else
    assign clip_hit = 1'b0;
`endif

    assign write_fire = gnt_any && !clip_hit;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        last_next  = last_reg;
        x_loc_next = x_loc_reg;
        y_loc_next = y_loc_reg;
        rgb_next   = rgb_reg;
        wr_en_next = 1'b0;
        if (gnt_any) begin
            last_next = gnt_idx;
        end
        if (write_fire) begin
            x_loc_next = sel_x;
            y_loc_next = sel_y;
            rgb_next   = sel_rgb;
            wr_en_next = 1'b1;
        end
    end

    // Pointer resets to 2 so requester 0 is searched first after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg  <= 2'd2;
            x_loc_reg <= 8'd0;
            y_loc_reg <= 8'd0;
            rgb_reg   <= 12'd0;
            wr_en_reg <= 1'b0;
        end else begin
            last_reg  <= last_next;
            x_loc_reg <= x_loc_next;
            y_loc_reg <= y_loc_next;
            rgb_reg   <= rgb_next;
            wr_en_reg <= wr_en_next;
        end
    end

    assign X_loc = x_loc_reg;
    assign Y_loc = y_loc_reg;
    assign RGB   = rgb_reg;
    assign WR_en = wr_en_reg;

    // -----------------------------------------------------------------------
    // Dropped-pixel counter
    // -----------------------------------------------------------------------
`ifdef PIXEL_CLIP_EN
    logic [15:0] drop_cnt_reg, drop_cnt_next;

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (gnt_any && clip_hit && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_next = drop_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_reg <= 16'd0;
        end else begin
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pixel_write_arbiter
//
// Stimulus drives requests on the falling edge and predicts the grant from
// the round-robin rule; every predicted write goes into a queue together with
// the cycle in which it must appear. A separate monitor checks WR_en and the
// pixel outputs after every rising edge against that queue.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pixel_write_arbiter;

    localparam int MAX_X = 120;
    localparam int MAX_Y = 120;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [23:0] x_in = '0;
    logic [23:0] y_in = '0;
    logic [35:0] rgb_in = '0;
    logic        fb_ready = 1'b0;
    logic [2:0]  gnt;
    logic [7:0]  X_loc;
    logic [7:0]  Y_loc;
    logic [11:0] RGB;
    logic        WR_en;
    logic [15:0] drop_cnt;

    pixel_write_arbiter #(
        .MAX_X (MAX_X),
        .MAX_Y (MAX_Y)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .x_in     (x_in),
        .y_in     (y_in),
        .rgb_in   (rgb_in),
        .gnt      (gnt),
        .fb_ready (fb_ready),
        .X_loc    (X_loc),
        .Y_loc    (Y_loc),
        .RGB      (RGB),
        .WR_en    (WR_en),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [11:0] c;
    } wr_t;

    wr_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state
    int          m_last = 2;
    int          m_drop = 0;
    logic [7:0]  m_x = 8'd0;
    logic [7:0]  m_y = 8'd0;
    logic [11:0] m_c = 12'd0;

    // Pixels currently presented by each requester
    logic [7:0]  px [3];
    logic [7:0]  py [3];
    logic [11:0] pc [3];
    bit          need_new [3];
    logic [2:0]  last_gnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply_pixels();
        for (int i = 0; i < 3; i++) begin
            x_in[8*i +: 8]    = px[i];
            y_in[8*i +: 8]    = py[i];
            rgb_in[12*i +: 12] = pc[i];
        end
    endtask

    task automatic rand_pix(input int i);
        px[i] = 8'($urandom_range(0, 130));
        py[i] = 8'($urandom_range(0, 130));
        pc[i] = 12'($urandom);
    endtask

    task automatic set_pix(input int i, input logic [7:0] x, input logic [7:0] y, input logic [11:0] c);
        px[i] = x;
        py[i] = y;
        pc[i] = c;
    endtask

    // One cycle of stimulus plus grant prediction.
    task automatic step(input logic [2:0] r, input bit rdy, input bit newdata);
        int idx;
        int j;
        bit clipped;
        @(negedge clk);
        chk("drop_cnt", drop_cnt, m_drop);
        for (int i = 0; i < 3; i++) begin
            // A requester may change its pixel only once granted or idle.
            if (newdata && (need_new[i] || !req[i])) begin
                rand_pix(i);
            end
            need_new[i] = 1'b0;
        end
        req      = r;
        fb_ready = rdy;
        apply_pixels();
        #1;
        idx = -1;
        if (rdy) begin
            for (int k = 1; k <= 3; k++) begin
                j = (m_last + k) % 3;
                if (idx < 0 && r[j]) idx = j;
            end
        end
        last_gnt = gnt;
        chk("gnt", gnt, (idx < 0) ? 0 : (1 << idx));
        if (idx >= 0) begin
            clipped = 1'b0;
`ifdef PIXEL_CLIP_EN
            clipped = (int'(px[idx]) > MAX_X) || (int'(py[idx]) > MAX_Y);
`endif
            m_last = idx;
            need_new[idx] = 1'b1;
            if (clipped) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                exp_q.push_back('{cyc + 1, px[idx], py[idx], pc[idx]});
            end
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_last = 2;
        m_drop = 0;
        m_x = 8'd0;
        m_y = 8'd0;
        m_c = 12'd0;
        for (int i = 0; i < 3; i++) need_new[i] = 1'b1;
    endtask

    // Asynchronous reset in the middle of a cycle with all requesters active.
    task automatic reset_mid();
        @(negedge clk);
        req      = 3'b111;
        fb_ready = 1'b1;
        apply_pixels();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_wr_en", WR_en, 0);
        chk("rst_x_loc", X_loc, 0);
        chk("rst_drop", drop_cnt, 0);
        clear_model();
        repeat (2) @(negedge clk);
        req = 3'b000;
        rst = 1'b0;
    endtask

    // Monitor: one check of the write port per rising edge.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("wr_en", WR_en, 1);
                m_x = e.x;
                m_y = e.y;
                m_c = e.c;
            end else begin
                chk("wr_en", WR_en, 0);
            end
            chk("x_loc", X_loc, m_x);
            chk("y_loc", Y_loc, m_y);
            chk("rgb", RGB, m_c);
            $display("cyc %0d: WR_en=%0b X=%0d Y=%0d RGB=%03h gnt=%03b", cyc, WR_en, X_loc, Y_loc, RGB, gnt);
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rand_pix(i);
            need_new[i] = 1'b1;
        end
        last_gnt = 3'b000;

        // Power-on reset with all requesters active: nothing may be granted.
        req      = 3'b111;
        fb_ready = 1'b1;
        apply_pixels();
        repeat (2) @(negedge clk);
        #1;
        chk("init_gnt", gnt, 0);
        chk("init_wr_en", WR_en, 0);
        chk("init_x_loc", X_loc, 0);
        chk("init_drop", drop_cnt, 0);
        @(negedge clk);
        req = 3'b000;
        rst = 1'b0;

        // Full contention: rotation 0,1,2,0,1,2 starting at requester 0.
        for (int s = 0; s < 6; s++) begin
            step(3'b111, 1'b1, 1'b1);
            chk("contend_seq", last_gnt, 3'b001 << (s % 3));
        end

        // Single requester granted every cycle with a held pixel.
        set_pix(1, 8'd5, 8'd7, 12'h0F0);
        for (int s = 0; s < 4; s++) begin
            step(3'b010, 1'b1, 1'b0);
            chk("single_gnt", last_gnt, 3'b010);
        end

        // Backpressure: no grants while fb_ready is low, then resume at
        // requester 2 (pointer is 1 after the single-requester run).
        for (int s = 0; s < 3; s++) begin
            step(3'b101, 1'b0, 1'b1);
            chk("bp_stall_gnt", last_gnt, 3'b000);
        end
        step(3'b101, 1'b1, 1'b1);
        chk("bp_resume_a", last_gnt, 3'b100);
        step(3'b101, 1'b1, 1'b1);
        chk("bp_resume_b", last_gnt, 3'b001);

        // Withdrawal: requester 1 asks for one cycle while requester 0 wins.
        step(3'b010, 1'b1, 1'b1);
        set_pix(1, 8'd99, 8'd98, 12'hABC);
        step(3'b011, 1'b1, 1'b0);
        chk("withdraw_gnt", last_gnt, 3'b001);
        step(3'b001, 1'b1, 1'b1);
        chk("withdraw_after", last_gnt, 3'b001);

        // Random traffic, with an asynchronous reset in the middle.
        for (int s = 0; s < 200; s++) begin
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), 1'b1);
        end
        reset_mid();
        step(3'b111, 1'b1, 1'b1);
        chk("post_rst_first", last_gnt, 3'b001);
        for (int s = 0; s < 200; s++) begin
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), 1'b1);
        end

`ifdef PIXEL_CLIP_EN
        // Clipped pixel is granted but not written; counter saturates.
        step(3'b000, 1'b1, 1'b1);
        set_pix(2, 8'd121, 8'd10, 12'h123);
        step(3'b100, 1'b1, 1'b0);
        chk("clip_gnt", last_gnt, 3'b100);
        step(3'b000, 1'b1, 1'b1);
        @(negedge clk);
        force dut.drop_cnt_reg = 16'hFFFF;
        #1;
        release dut.drop_cnt_reg;
        m_drop = 65535;
        set_pix(2, 8'd121, 8'd10, 12'h321);
        step(3'b100, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b1);
        chk("clip_saturate", drop_cnt, 16'hFFFF);
`endif

        // Drain and make sure every predicted write appeared.
        for (int s = 0; s < 3; s++) begin
            step(3'b000, 1'b1, 1'b1);
        end
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Shares the single framebuffer pixel-write port of the LCM_VGA design between three pixel-drawing requesters, such as the line generator, trace plotter and text overlay. Each requester holds a pixel (X, Y, RGB) with a level request. The arbiter grants one requester per cycle in round-robin order and issues a registered one-cycle write to the framebuffer. Writes are only issued while the framebuffer signals it can accept them.

## Interface
Parameters:
- MAX_X, 120, largest valid X coordinate (inclusive); used only by clipping.
- MAX_Y, 120, largest valid Y coordinate (inclusive); used only by clipping.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  3  per-requester write request; bit i belongs to requester i.
- x_in  in  24  requester X coordinates, 8 bits each; requester i uses [8i+7:8i].
- y_in  in  24  requester Y coordinates, 8 bits each, same packing as x_in.
- rgb_in  in  36  requester colours, 12 bits each; requester i uses [12i+11:12i].
- gnt  out  3  one-hot combinational grant; at most one bit is high.
- fb_ready  in  1  framebuffer can accept a write; when low, no grants are issued.
- X_loc  out  8  registered pixel X to the framebuffer.
- Y_loc  out  8  registered pixel Y to the framebuffer.
- RGB  out  12  registered pixel colour to the framebuffer.
- WR_en  out  1  registered single-cycle write strobe.
- drop_cnt  out  16  saturating count of clipped (discarded) pixels.

## Operation
- Request and grant handshake:
  - A requester raises req[i] and holds its pixel data stable until it samples gnt[i]=1 on a rising edge.
  - The requester may then present the next pixel with req[i] held high, or drop req[i].
  - Deasserting req[i] before it is granted is legal; the request is simply withdrawn.
- Grant generation:
  - gnt is combinational from req, the round-robin pointer `last` (2 bits, values 0..2) and fb_ready.
  - If fb_ready=0 or req=0, then gnt=0.
  - Otherwise the grant goes to the first requester with a request, searching in order last+1, last+2, last (indices mod 3).
- Pointer update:
  - On each rising edge with a grant, last ← granted index.
  - Without a grant, last holds its value.
  - Reset value is last=2, so requester 0 has top priority after reset.
- Write issue:
  - On the edge that ends a grant cycle, X_loc/Y_loc/RGB ← the granted requester's data, and WR_en ← 1.
  - On any edge without a grant, WR_en ← 0 and X_loc/Y_loc/RGB hold their values.
- Fairness: with all three requesters continuously requesting, grants rotate 0,1,2,0,… and each requester is served at least once every 3 granting cycles.
- Reset values (asynchronous):
  - X_loc=0, Y_loc=0, RGB=0, WR_en=0, drop_cnt=0, last=2.
  - gnt is 0 while rst=1.
- Reset mid-operation: any pending grant and its write are lost. Requesters restart their handshake after reset.
- fb_ready changes: fb_ready only gates new grants. A WR_en pulse already registered always completes, and the framebuffer must accept it.

## Timing
- Request-to-write latency: a grant in cycle t gives WR_en=1 with the pixel data in cycle t+1 (one register stage).
- Throughput: one pixel per cycle while fb_ready=1 and any req is high. Back-to-back WR_en pulses are allowed.
- A single continuously requesting requester (others idle) receives a grant every cycle.
- An fb_ready=0 cycle produces WR_en=0 in the following cycle.

## Configuration
- PIXEL_CLIP_EN defined:
  - A granted pixel with X>MAX_X or Y>MAX_Y is still granted, so the requester advances.
  - It produces WR_en=0 on the next cycle, and X_loc/Y_loc/RGB hold their values.
  - drop_cnt increments by 1 and saturates at 16'hFFFF.
- PIXEL_CLIP_EN undefined:
  - No coordinate check; every grant produces a write.
  - drop_cnt is tied to 0.
  - MAX_X and MAX_Y are unused.

## Test plan
- Reset check: assert rst asynchronously mid-cycle while req=3'b111 → gnt=0 immediately; WR_en=0, X_loc=0, drop_cnt=0; first grant after release goes to requester 0.
- Single requester: req=3'b010 with x=5, y=7, rgb=12'h0F0 held for 4 cycles → gnt=3'b010 every cycle; WR_en=1 on cycles 2–5 with X_loc=5, Y_loc=7, RGB=12'h0F0.
- Full contention: req=3'b111 for 6 cycles → gnt sequence 001,010,100,001,010,100; WR_en data follows one cycle later in the same order.
- Backpressure: req=3'b101 and fb_ready low for 3 cycles → gnt=0 and WR_en=0 during the stall (delayed by one cycle); on fb_ready high, grants resume from the saved pointer without skipping anyone.
- Withdrawal: requester 1 raises req for one cycle while requester 0 holds the grant, then drops it → requester 1 is never granted and no write with its data appears.
- Clip (PIXEL_CLIP_EN defined): requester 2 presents x=121, y=10 → gnt[2]=1, no WR_en next cycle, drop_cnt 0→1; after forcing drop_cnt to 16'hFFFF, a further clip leaves it at 16'hFFFF.
